obi_bridge_initiator: RTL and testbench
=======================================

# obi_bridge_initiator

OBI initiator that turns a valid/ready command stream into bus transactions on the testharness bridge port (`req`/`we`/`be`/`addr`/`wdata` → `gnt`/`rvalid`/`rdata`). It sits on the testbench/host side, facing the harness bridge responder. It pipelines up to `MAX_OUTSTANDING` transactions and returns one response per command, in order, through a buffered valid/ready response stream.

## Interface
- `MAX_OUTSTANDING`, 2: maximum number of issued commands whose response has not yet been popped; also the response FIFO depth (≥1).
- `TIMEOUT_CYCLES`, 1024: watchdog limit; only used with `OBI_BRIDGE_TIMEOUT_EN`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  command accepted when high together with `cmd_valid_i`.
- `cmd_we_i`  in  1  1 = write.
- `cmd_be_i`  in  4  byte enables.
- `cmd_addr_i`  in  32  address.
- `cmd_wdata_i`  in  32  write data.
- `req_o`  out  1  OBI request.
- `we_o`  out  1  OBI write enable.
- `be_o`  out  4  OBI byte enables.
- `addr_o`  out  32  OBI address.
- `wdata_o`  out  32  OBI write data.
- `gnt_i`  in  1  OBI grant.
- `rvalid_i`  in  1  OBI response valid.
- `rdata_i`  in  32  OBI read data.
- `rsp_valid_o`  out  1  response available.
- `rsp_ready_i`  in  1  response consumed when high together with `rsp_valid_o`.
- `rsp_we_o`  out  1  response belongs to a write.
- `rsp_rdata_o`  out  32  read data; 0 for writes.
- `err_o`  out  1  sticky protocol/timeout error.

## Operation
- Request register holds `{we,be,addr,wdata}`. `req_o` stays high with stable payload until `gnt_i`.
- `credits` counts accepted commands not yet popped from the response stream. Width is `$clog2(MAX_OUTSTANDING+1)`. Accept increments it, pop decrements it, and simultaneous accept and pop leave it unchanged.
- `cmd_ready_o = (~req_o | gnt_i) & (credits < MAX_OUTSTANDING)`. This reserves a FIFO slot for every issued command, so the bridge never drops or stalls `rvalid_i`.
- Order-tracking FIFO (depth `MAX_OUTSTANDING`):
  - records `we` at grant time;
  - on `rvalid_i`, the head entry pairs with `rdata_i`, and `rdata` is forced to 0 if `we`;
  - the result is pushed into the response FIFO.
- Responses pop in issue order.
- `rvalid_i` while nothing is in flight is a protocol error. It is dropped, and `err_o` is set regardless of macro.
- `err_o` clears only on reset.

## Timing
- Reset values: `req_o`, `we_o`, `rsp_valid_o`, `rsp_we_o`, `err_o` = 0; `be_o` = 0; `addr_o`, `wdata_o`, `rsp_rdata_o` = 0; `credits` = 0; FIFOs empty.
- Accept at edge N → `req_o` = 1 from cycle N+1.
- If `gnt_i` arrives in the same cycle as the request, back-to-back accept is allowed: one request per cycle at full throughput.
- `rvalid_i` at cycle M → `rsp_valid_o` = 1 from M+1 (registered FIFO output).
- Minimum command-to-response latency is 3 cycles with an immediate grant and an `rvalid` one cycle later.
- Response FIFO full with `rsp_ready_i` low → `credits` saturates and `cmd_ready_o` = 0. No overflow is possible.
- Response FIFO empty → `rsp_valid_o` = 0. Push and pop in the same cycle on a non-empty FIFO keep occupancy unchanged.
- FIFO pointers wrap modulo `MAX_OUTSTANDING`, which need not be a power of two.
- Reset mid-transaction: `req_o` drops at the reset edge and all state clears. `rvalid_i` arriving after reset for pre-reset traffic is treated as a protocol error.

## Configuration
- `OBI_BRIDGE_TIMEOUT_EN` defined:
  - a counter increments on each cycle where `req_o & ~gnt_i`, or where in-flight > 0 with no `rvalid_i`;
  - it resets on any `gnt_i`/`rvalid_i` and when idle;
  - reaching `TIMEOUT_CYCLES` sets `err_o`, drops `req_o`, and flushes in-flight entries by pushing one `rdata` = 32'hDEAD_BEEF response per lost transaction. This keeps the response count equal to the command count.
- Undefined: no counter is built, and `err_o` reflects only unexpected `rvalid_i`.

## Structure
- `obi_bridge_pkg` holds:
  - `obi_cmd_t` (we, be, addr, wdata);
  - `obi_rsp_t` (we, rdata);
  - `OBI_TIMEOUT_DATA` = 32'hDEAD_BEEF.
- One sub-module: `obi_bridge_fifo`, a parameterised synchronous FIFO (width, depth) with full/empty and registered output. It is instantiated twice: for order tracking and for responses.

## Test plan
- Single read: accept read `addr` 0x0000_0180, grant same cycle, `rvalid` next cycle with `rdata` 0x1234_5678 → exactly one response `we`=0, `rdata`=0x1234_5678, 3 cycles after accept.
- Write then read: write `be`=4'b0011 `wdata`=0xAABB_CCDD, then read the same address; responder returns 0x0000_CCDD → responses in order: `we`=1 `rdata`=0, then `we`=0 `rdata`=0x0000_CCDD.
- Grant stall: responder holds `gnt_i`=0 for 5 cycles → `req_o` and payload stable for all 6 cycles and `cmd_ready_o`=0 throughout.
- Backpressure: `MAX_OUTSTANDING`=2, `rsp_ready_i`=0, 3 commands offered → only 2 accepted, `cmd_ready_o`=0 after the second; one pop → third accepted on the next cycle.
- Spurious `rvalid_i` with nothing in flight → no response, `err_o`=1 and held until `rst_ni`=0.
- With `OBI_BRIDGE_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: responder never grants → `err_o`=1 after 16 stalled cycles, `req_o`=0, one response with `rdata`=0xDEAD_BEEF.

Source files
------------

// File: rtl/obi_bridge_pkg.sv
// Shared types for the OBI bridge initiator: command/response payloads and the
// read data returned for transactions lost to the watchdog.
package obi_bridge_pkg;

  localparam logic [31:0] OBI_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_cmd_t;

  typedef struct packed {
    logic        we;
    logic [31:0] rdata;
  } obi_rsp_t;

endpackage

// File: rtl/obi_bridge_fifo.sv
// Synchronous FIFO with arbitrary (non power-of-two) depth; output reads as 0
// while empty so downstream data is clean after reset.
module obi_bridge_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= bump(wptr);
      if (do_pop)  rptr <= bump(rptr);
      if (do_push & ~do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop & ~do_push) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/obi_bridge_initiator.sv
// OBI initiator: valid/ready commands in, in-order responses out, up to
// MAX_OUTSTANDING in flight. Optional watchdog under OBI_BRIDGE_TIMEOUT_EN.
module obi_bridge_initiator
  import obi_bridge_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_be_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        req_o,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_we_o,
  output logic [31:0] rsp_rdata_o,
  output logic        err_o
);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  if (MAX_OUTSTANDING == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
  end

  obi_cmd_t      cmd;
  logic          req;
  logic [CW-1:0] credits;
  logic          err;
  logic          accept, grant, unexpected, fire, flush;
  logic          ord_push, ord_pop, ord_din, ord_dout, ord_full, ord_empty;
  obi_rsp_t      rsp_din, rsp_dout;
  logic          rsp_push, rsp_pop, rsp_full, rsp_empty;

`ifdef OBI_BRIDGE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;
  state_t        state;
  logic [TW-1:0] tcnt;
  logic          stall;

  assign stall = (req & ~gnt_i) | (~ord_empty & ~rvalid_i);
  assign fire  = (state == ST_RUN) & stall & ~gnt_i & ~rvalid_i &
                 (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign flush = (state == ST_FLUSH);

  // Flush drains one lost transaction per cycle until the order FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= ST_RUN;
      tcnt  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (fire) begin
            state <= ST_FLUSH;
            tcnt  <= '0;
          end else if (gnt_i | rvalid_i | ~stall) begin
            tcnt <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_FLUSH: if (ord_empty) state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end
`else
  assign fire  = 1'b0;
  assign flush = 1'b0;
`endif

  // A credit per accepted command guarantees a response slot, so rvalid_i never stalls.
  assign cmd_ready_o = (~req | gnt_i) & (credits < CW'(MAX_OUTSTANDING)) &
                       ~rsp_full & ~flush & ~fire;
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign grant       = req & gnt_i;

  // On timeout the still-pending request joins the order FIFO so it is flushed too.
  assign ord_push   = (grant | (fire & req)) & ~ord_full;
  assign ord_din    = cmd.we;
  assign unexpected = rvalid_i & (ord_empty | flush);
  assign ord_pop    = ~ord_empty & (flush | rvalid_i);
  assign rsp_push   = ord_pop;
  assign rsp_din    = {ord_dout, flush ? OBI_TIMEOUT_DATA : (ord_dout ? 32'h0 : rdata_i)};
  assign rsp_pop    = rsp_ready_i & ~rsp_empty;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req <= 1'b0;
      cmd <= '0;
    end else if (accept) begin
      req <= 1'b1;
      cmd <= '{we: cmd_we_i, be: cmd_be_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
    end else if (grant | fire) begin
      req <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      credits <= '0;
    end else begin
      case ({accept, rsp_pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)                err <= 1'b0;
    else if (unexpected | fire) err <= 1'b1;
  end

  obi_bridge_fifo #(.WIDTH(1), .DEPTH(MAX_OUTSTANDING)) u_order_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (ord_push),
    .din   (ord_din),
    .pop   (ord_pop),
    .dout  (ord_dout),
    .full  (ord_full),
    .empty (ord_empty)
  );

  obi_bridge_fifo #(.WIDTH($bits(obi_rsp_t)), .DEPTH(MAX_OUTSTANDING)) u_rsp_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (rsp_push),
    .din   (rsp_din),
    .pop   (rsp_pop),
    .dout  (rsp_dout),
    .full  (rsp_full),
    .empty (rsp_empty)
  );

  assign req_o       = req;
  assign we_o        = cmd.we;
  assign be_o        = cmd.be;
  assign addr_o      = cmd.addr;
  assign wdata_o     = cmd.wdata;
  assign rsp_valid_o = ~rsp_empty;
  assign rsp_we_o    = rsp_dout.we;
  assign rsp_rdata_o = rsp_dout.rdata;
  assign err_o       = err;

endmodule

// File: tb/tb_obi_bridge_initiator.sv
// Bench: queue-based model of command/grant/response ordering checked every
// cycle, plus directed scenarios with literal expectations.
module tb_obi_bridge_initiator;
  import obi_bridge_pkg::*;

  localparam int MAXO = 2;
  localparam int TOC  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        rsp_valid, rsp_ready, rsp_we;
  logic [31:0] rsp_rdata;
  logic        err;

  always #5 clk = ~clk;

  obi_bridge_initiator #(.MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TOC)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_be_i(cmd_be), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .req_o(req), .we_o(we), .be_o(be), .addr_o(addr), .wdata_o(wdata),
    .gnt_i(gnt), .rvalid_i(rvalid), .rdata_i(rdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_we_o(rsp_we),
    .rsp_rdata_o(rsp_rdata), .err_o(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: accepted-not-granted, granted-not-answered, answered-not-popped
  obi_cmd_t cmd_q[$];
  logic     fly_q[$];
  obi_rsp_t rsp_q[$];
  logic     err_m = 1'b0;
  int       tcnt_m = 0;
  int       grace = 0;
  bit       started = 0;
  logic     rst_seen = 1'b0;

  initial begin
    logic acc, gn, rv, pp, rst_cap, fire_now;
    obi_cmd_t c, h;
    logic [31:0] rd;
    logic w;
    forever begin
      @(negedge clk); #1;
      fire_now = 1'b0;
`ifdef OBI_BRIDGE_TIMEOUT_EN
      if ((((cmd_q.size() > 0) && !gnt) || ((fly_q.size() > 0) && !rvalid)) &&
          !gnt && !rvalid && (tcnt_m + 1 == TOC))
        fire_now = 1'b1;
`endif
      if (started && !rst_seen) begin
        chk("reset_outputs", 128'({req, we, be, addr, wdata, rsp_valid, rsp_we, rsp_rdata, err}), 128'(0));
      end else if (started) begin
        chk("req_o", 128'(req), 128'(cmd_q.size() > 0));
        if (cmd_q.size() > 0)
          chk("payload", 128'({we, be, addr, wdata}), 128'(cmd_q[0]));
        if (grace == 0) begin
          chk("cmd_ready", 128'(cmd_ready),
              128'(((cmd_q.size() == 0) || gnt) &&
                   ((cmd_q.size() + fly_q.size() + rsp_q.size()) < MAXO) && !fire_now));
          chk("rsp_valid", 128'(rsp_valid), 128'(rsp_q.size() > 0));
          if (rsp_q.size() > 0)
            chk("rsp_data", 128'({rsp_we, rsp_rdata}), 128'(rsp_q[0]));
        end
        chk("err", 128'(err), 128'(err_m));
      end
      rst_cap = rst_n;
      acc = cmd_valid && cmd_ready;
      gn  = gnt && (cmd_q.size() > 0);
      rv  = rvalid;
      pp  = rsp_valid && rsp_ready;
      c   = '{we: cmd_we, be: cmd_be, addr: cmd_addr, wdata: cmd_wdata};
      rd  = rdata;
      @(posedge clk);
      started  = 1;
      rst_seen = rst_cap;
      if (!rst_cap) begin
        cmd_q.delete(); fly_q.delete(); rsp_q.delete();
        err_m = 1'b0; tcnt_m = 0; grace = 0;
      end else begin
        if (grace > 0) grace--;
        if (fire_now) begin
          err_m = 1'b1; tcnt_m = 0; grace = MAXO + 2;
          foreach (fly_q[i]) rsp_q.push_back('{we: fly_q[i], rdata: OBI_TIMEOUT_DATA});
          foreach (cmd_q[i]) rsp_q.push_back('{we: cmd_q[i].we, rdata: OBI_TIMEOUT_DATA});
          fly_q.delete(); cmd_q.delete();
        end else begin
`ifdef OBI_BRIDGE_TIMEOUT_EN
          if (gnt || rvalid) tcnt_m = 0;
          else if (((cmd_q.size() > 0) && !gnt) || ((fly_q.size() > 0) && !rvalid)) tcnt_m++;
          else tcnt_m = 0;
`endif
          if (pp && rsp_q.size() > 0) void'(rsp_q.pop_front());
          if (rv) begin
            if (fly_q.size() == 0) err_m = 1'b1;
            else begin
              w = fly_q.pop_front();
              rsp_q.push_back('{we: w, rdata: w ? 32'h0 : rd});
            end
          end
          if (gn) begin
            h = cmd_q.pop_front();
            fly_q.push_back(h.we);
          end
          if (acc) cmd_q.push_back(c);
        end
      end
    end
  end

  task automatic idle();
    cmd_valid = 0; cmd_we = 0; cmd_be = 0; cmd_addr = 0; cmd_wdata = 0;
    gnt = 0; rvalid = 0; rdata = 0; rsp_ready = 1;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic put(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1; cmd_we = w; cmd_be = b; cmd_addr = a; cmd_wdata = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gw, rw;
    idle();
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;

    // single read, 3-cycle latency
    nxt(); put(0, 4'hF, 32'h0000_0180, 0);
    #2 chk("t1_ready", 128'(cmd_ready), 128'(1));
    nxt(); gnt = 1;
    #2 chk("t1_req", 128'({req, addr}), 128'({1'b1, 32'h0000_0180}));
    nxt(); rvalid = 1; rdata = 32'h1234_5678;
    #2 chk("t1_rsp_early", 128'(rsp_valid), 128'(0));
    nxt();
    #2 chk("t1_rsp", 128'({rsp_valid, rsp_we, rsp_rdata}), 128'({2'b10, 32'h1234_5678}));
    nxt();
    #2 chk("t1_rsp_gone", 128'(rsp_valid), 128'(0));

    // write then read, in-order responses
    nxt(); rsp_ready = 0; put(1, 4'b0011, 32'h0000_0200, 32'hAABB_CCDD);
    nxt(); rsp_ready = 0; put(0, 4'hF, 32'h0000_0200, 0); gnt = 1;
    #2 chk("t2_b2b_ready", 128'(cmd_ready), 128'(1));
    chk("t2_wr_bus", 128'({we, be, wdata}), 128'({1'b1, 4'b0011, 32'hAABB_CCDD}));
    nxt(); rsp_ready = 0; gnt = 1; rvalid = 1; rdata = 32'hFFFF_FFFF;
    nxt(); rsp_ready = 0; rvalid = 1; rdata = 32'h0000_CCDD;
    nxt();
    #2 chk("t2_rsp0", 128'({rsp_valid, rsp_we, rsp_rdata}), 128'({2'b11, 32'h0}));
    nxt();
    #2 chk("t2_rsp1", 128'({rsp_valid, rsp_we, rsp_rdata}), 128'({2'b10, 32'h0000_CCDD}));
    nxt();

    // grant stall: payload held, no accept
    nxt(); put(0, 4'hF, 32'h0000_0300, 0);
    for (int i = 1; i <= 5; i++) begin
      nxt(); put(0, 4'hF, 32'h0000_0304, 0);
      #2 chk("t3_stall", 128'({req, addr, cmd_ready}), 128'({1'b1, 32'h0000_0300, 1'b0}));
    end
    nxt(); put(0, 4'hF, 32'h0000_0304, 0); gnt = 1;
    #2 chk("t3_grant", 128'({req, addr, cmd_ready}), 128'({1'b1, 32'h0000_0300, 1'b1}));
    nxt(); gnt = 1;
    #2 chk("t3_second", 128'(addr), 128'(32'h0000_0304));
    nxt(); rvalid = 1; rdata = 32'h0BAD_F00D;
    nxt(); rvalid = 1; rdata = 32'h600D_CAFE;
    repeat (3) nxt();

    // backpressure with MAX_OUTSTANDING = 2
    nxt(); rsp_ready = 0; put(0, 4'hF, 32'h0000_0400, 0);
    nxt(); rsp_ready = 0; put(0, 4'hF, 32'h0000_0404, 0); gnt = 1;
    #2 chk("t4_ready_b", 128'(cmd_ready), 128'(1));
    nxt(); rsp_ready = 0; put(0, 4'hF, 32'h0000_0408, 0); gnt = 1; rvalid = 1; rdata = 32'h11;
    #2 chk("t4_block0", 128'(cmd_ready), 128'(0));
    nxt(); rsp_ready = 0; put(0, 4'hF, 32'h0000_0408, 0); rvalid = 1; rdata = 32'h22;
    #2 chk("t4_block1", 128'(cmd_ready), 128'(0));
    nxt(); put(0, 4'hF, 32'h0000_0408, 0);
    #2 chk("t4_block2", 128'(cmd_ready), 128'(0));
    nxt(); rsp_ready = 0; put(0, 4'hF, 32'h0000_0408, 0);
    #2 chk("t4_after_pop", 128'(cmd_ready), 128'(1));
    nxt(); rsp_ready = 0; gnt = 1;
    #2 chk("t4_third", 128'({req, addr}), 128'({1'b1, 32'h0000_0408}));
    nxt(); rsp_ready = 0; rvalid = 1; rdata = 32'h33;
    repeat (4) nxt();

    // spurious rvalid
    nxt(); rvalid = 1; rdata = 32'h55;
    for (int i = 0; i < 4; i++) begin
      nxt();
      #2 chk("t5_err", 128'({err, rsp_valid}), 128'({1'b1, 1'b0}));
    end
    nxt(); rst_n = 0;
    nxt();
    #2 chk("t5_err_clr", 128'(err), 128'(0));
    rst_n = 1;

    // reset mid-transaction; late rvalid is an error
    nxt(); put(0, 4'hF, 32'h0000_0500, 0);
    nxt(); gnt = 1;
    nxt(); rst_n = 0;
    nxt(); rst_n = 1;
    #2 chk("t6_req_drop", 128'(req), 128'(0));
    nxt(); rvalid = 1; rdata = 32'h66;
    nxt();
    #2 chk("t6_late_err", 128'({err, rsp_valid}), 128'({1'b1, 1'b0}));
    nxt(); rst_n = 0;
    nxt(); rst_n = 1;

    // randomized traffic with a legal, bounded-latency responder
    gw = 0; rw = 0;
    for (int i = 0; i < 3000; i++) begin
      nxt();
      if ($urandom_range(0, 99) < 70)
        put(1'($urandom), 4'($urandom), $urandom, $urandom);
      else begin
        cmd_we = 1'($urandom); cmd_addr = $urandom;
      end
      if (grace == 0 && cmd_q.size() > 0 && (gw >= 6 || $urandom_range(0, 99) < 50)) gnt = 1;
      if (grace == 0 && fly_q.size() > 0 && (rw >= 6 || $urandom_range(0, 99) < 50)) begin
        rvalid = 1; rdata = $urandom;
      end
      rsp_ready = ($urandom_range(0, 99) < 60);
      gw = (cmd_q.size() > 0 && !gnt) ? gw + 1 : 0;
      rw = (fly_q.size() > 0 && !rvalid) ? rw + 1 : 0;
    end
    for (int i = 0; i < 100; i++) begin
      nxt();
      if (cmd_q.size() + fly_q.size() + rsp_q.size() == 0) break;
      if (cmd_q.size() > 0) gnt = 1;
      if (fly_q.size() > 0) begin rvalid = 1; rdata = $urandom; end
    end
    chk("drain_empty", 128'(cmd_q.size() + fly_q.size() + rsp_q.size()), 128'(0));
    chk("rand_no_err", 128'(err), 128'(0));

`ifdef OBI_BRIDGE_TIMEOUT_EN
    // responder never grants
    nxt(); rsp_ready = 0; put(0, 4'hF, 32'h0000_0600, 0);
    for (int i = 1; i <= 16; i++) begin
      nxt(); rsp_ready = 0;
    end
    #2 chk("t7_err_before", 128'(err), 128'(0));
    nxt(); rsp_ready = 0;
    #2 chk("t7_fire", 128'({err, req}), 128'({1'b1, 1'b0}));
    repeat (3) begin nxt(); rsp_ready = 0; end
    #2 chk("t7_rsp", 128'({rsp_valid, rsp_we, rsp_rdata}), 128'({2'b10, 32'hDEAD_BEEF}));
    nxt();
    nxt();
    #2 chk("t7_one_rsp", 128'(rsp_valid), 128'(0));
`endif

    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
